// File: rtl/uart_rx_frame_sampler.sv
// UART receive front end: synchronises and oversamples rx_in, majority-votes each bit,
// deserialises LSB first and flags frame completion or framing faults.
module uart_rx_frame_sampler #(
   parameter int DATA_WIDTH = 8,
   parameter int OVERSAMPLE = 16
) (
   input  logic                  UCLK,
   input  logic                  reset,
   input  logic                  rx_in,
   input  logic                  parity_en,
   output logic [DATA_WIDTH-1:0] parallel_data,
   output logic                  sampled_bit,
   output logic                  par_chk_en,
   output logic                  data_valid,
   output logic                  stop_error,
   output logic                  start_glitch,
   output logic                  busy
);

   localparam int EW  = $clog2(OVERSAMPLE);
   localparam int BW  = $clog2(DATA_WIDTH + 1);
   localparam int MID = OVERSAMPLE / 2;

   localparam logic [EW-1:0] CNT_SAMPLE0 = EW'(MID - 1);
   localparam logic [EW-1:0] CNT_SAMPLE1 = EW'(MID);
   localparam logic [EW-1:0] CNT_SAMPLE2 = EW'(MID + 1);
   localparam logic [EW-1:0] CNT_STROBE  = EW'(MID + 2);
   localparam logic [EW-1:0] CNT_LAST    = EW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] BITS_FULL   = BW'(DATA_WIDTH);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } state_t;

   state_t                r_state;
   state_t                w_nextState;
   logic                  r_sync1;
   logic                  r_sync2;
   logic                  r_rxPrev;
   logic [EW-1:0]         r_edgeCnt;
   logic [BW-1:0]         r_bitCnt;
   logic [DATA_WIDTH-1:0] r_shift;
   logic                  r_sampleA;
   logic                  r_sampleB;
   logic                  r_sampledBit;
   logic                  r_parityEn;
   logic                  w_rxS;
   logic                  w_fallEdge;
   logic                  w_strobe;
   logic                  w_bitEnd;

   assign w_rxS         = r_sync2;
   assign w_fallEdge    = r_rxPrev & ~w_rxS;
   assign w_strobe      = (r_edgeCnt == CNT_STROBE);
   assign w_bitEnd      = (r_edgeCnt == CNT_LAST);
   assign parallel_data = r_shift;
   assign sampled_bit   = r_sampledBit;

   // Synchroniser resets to the idle-high line level so reset release never fakes a start edge.
   always_ff @(posedge UCLK or negedge reset) begin
      if (!reset) begin
         r_sync1  <= 1'b1;
         r_sync2  <= 1'b1;
         r_rxPrev <= 1'b1;
      end else begin
         r_sync1  <= rx_in;
         r_sync2  <= r_sync1;
         r_rxPrev <= r_sync2;
      end
   end

   always_ff @(posedge UCLK or negedge reset) begin
      if (!reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Strobes are decoded from the current state, so an asynchronous reset clears them at once.
   always_comb begin
      w_nextState  = r_state;
      par_chk_en   = 1'b0;
      data_valid   = 1'b0;
      stop_error   = 1'b0;
      start_glitch = 1'b0;
      busy         = (r_state != IDLE);
      case (r_state)
         IDLE: begin
            if (w_fallEdge) begin
               w_nextState = START;
            end
         end
         START: begin
            if (w_strobe && r_sampledBit) begin
               start_glitch = 1'b1;
               w_nextState  = IDLE;
            end else if (w_bitEnd) begin
               w_nextState = DATA;
            end
         end
         DATA: begin
            if (w_bitEnd && (r_bitCnt == BITS_FULL)) begin
               w_nextState = r_parityEn ? PARITY : STOP;
            end
         end
         PARITY: begin
            par_chk_en = w_strobe;
            if (w_bitEnd) begin
               w_nextState = STOP;
            end
         end
         STOP: begin
            if (w_strobe) begin
               data_valid  = r_sampledBit;
               stop_error  = ~r_sampledBit;
               w_nextState = IDLE;
            end
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   // The edge counter free-runs while busy; a power-of-two OVERSAMPLE lets it wrap on its own.
   always_ff @(posedge UCLK or negedge reset) begin
      if (!reset) begin
         r_edgeCnt    <= '0;
         r_bitCnt     <= '0;
         r_shift      <= '0;
         r_sampleA    <= 1'b0;
         r_sampleB    <= 1'b0;
         r_sampledBit <= 1'b0;
         r_parityEn   <= 1'b0;
      end else begin
         if ((r_state == IDLE) || (w_nextState == IDLE)) begin
            r_edgeCnt <= '0;
         end else begin
            r_edgeCnt <= r_edgeCnt + 1'b1;
         end

         if ((r_state == IDLE) && w_fallEdge) begin
            r_parityEn <= parity_en;
         end

         if (r_state != IDLE) begin
            if (r_edgeCnt == CNT_SAMPLE0) begin
               r_sampleA <= w_rxS;
            end
            if (r_edgeCnt == CNT_SAMPLE1) begin
               r_sampleB <= w_rxS;
            end
            if (r_edgeCnt == CNT_SAMPLE2) begin
               r_sampledBit <= (r_sampleA & r_sampleB) | (r_sampleA & w_rxS) | (r_sampleB & w_rxS);
            end
         end

         if ((r_state == START) && (w_nextState == DATA)) begin
            r_bitCnt <= '0;
         end else if ((r_state == DATA) && w_strobe) begin
            r_bitCnt <= r_bitCnt + 1'b1;
            r_shift  <= {r_sampledBit, r_shift[DATA_WIDTH-1:1]};
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_frame_sampler.sv
// Directed bench for uart_rx_frame_sampler: a table of whole frames plus hand-written
// sequences for start glitches, noisy back-to-back frames and mid-frame reset.
module tb_uart_rx_frame_sampler;

   localparam int BIT_CYCLES   = 16;
   localparam int LAT_PARITY   = 173;
   localparam int LAT_NOPARITY = 157;
   localparam int LAT_GLITCH   = 13;

   logic       UCLK;
   logic       reset;
   logic       rx_in;
   logic       parity_en;
   logic [7:0] parallel_data;
   logic       sampled_bit;
   logic       par_chk_en;
   logic       data_valid;
   logic       stop_error;
   logic       start_glitch;
   logic       busy;

   int assertCount;
   int failCount;
   int cycleCount;
   int dvCount;
   int seCount;
   int pcCount;
   int sgCount;
   int exclusiveViolations;
   int endCycle;
   int glitchCycle;
   int frameStart;
   logic [7:0] pcData;
   logic       pcBit;
   logic [7:0] dvLog[$];

   typedef struct {
      logic [7:0] data;
      logic       parEn;
      logic       parBit;
      logic       stopBit;
      int         expDv;
      int         expStopErr;
      int         expParChk;
      int         expParBit;
      int         expLatency;
   } vec_t;

   vec_t vecs[5];

   uart_rx_frame_sampler #(
      .DATA_WIDTH(8),
      .OVERSAMPLE(16)
   ) dut (
      .UCLK         (UCLK),
      .reset        (reset),
      .rx_in        (rx_in),
      .parity_en    (parity_en),
      .parallel_data(parallel_data),
      .sampled_bit  (sampled_bit),
      .par_chk_en   (par_chk_en),
      .data_valid   (data_valid),
      .stop_error   (stop_error),
      .start_glitch (start_glitch),
      .busy         (busy)
   );

   // 10 ns oversampling clock.
   initial begin
      UCLK = 1'b0;
      forever #5 UCLK = ~UCLK;
   end

   always @(posedge UCLK) cycleCount <= cycleCount + 1;

   // Strobe monitor samples on the falling edge, away from the active edge.
   always @(negedge UCLK) begin
      if (data_valid) begin
         dvCount++;
         dvLog.push_back(parallel_data);
         endCycle = cycleCount;
      end
      if (stop_error) begin
         seCount++;
         endCycle = cycleCount;
      end
      if (par_chk_en) begin
         pcCount++;
         pcData = parallel_data;
         pcBit  = sampled_bit;
      end
      if (start_glitch) begin
         sgCount++;
         glitchCycle = cycleCount;
      end
      if ((data_valid && stop_error) || (start_glitch && (data_valid || stop_error))) begin
         exclusiveViolations++;
      end
   end

   task automatic checkOutput(input string name, input int actual, input int expected);
      assertCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, actual, actual,
                  expected, expected);
      end
   endtask

   // One bit period; an optional 1-cycle inverted spike lands on the edge_cnt==MID sample.
   task automatic driveBit(input logic value, input bit spike);
      for (int i = 0; i < BIT_CYCLES; i++) begin
         rx_in = (spike && (i == 9)) ? ~value : value;
         @(posedge UCLK);
         #1;
      end
   endtask

   // parity_en is flipped after the start bit to show the latched value is used.
   task automatic applyStimulus(input logic [7:0] data, input logic parEn, input logic parBit,
                                input logic stopBit, input bit spike);
      parity_en  = parEn;
      frameStart = cycleCount;
      driveBit(1'b0, 1'b0);
      parity_en = ~parEn;
      for (int b = 0; b < 8; b++) begin
         driveBit(data[b], spike);
      end
      if (parEn) begin
         driveBit(parBit, 1'b0);
      end
      driveBit(stopBit, 1'b0);
      rx_in = 1'b1;
   endtask

   task automatic idleCycles(input int n);
      rx_in = 1'b1;
      repeat (n) @(posedge UCLK);
      #1;
   endtask

   initial begin
      int dv0;
      int se0;
      int pc0;
      int sg0;

      assertCount = 0;
      failCount = 0;
      cycleCount = 0;
      dvCount = 0;
      seCount = 0;
      pcCount = 0;
      sgCount = 0;
      exclusiveViolations = 0;
      endCycle = 0;
      glitchCycle = 0;
      frameStart = 0;
      pcData = '0;
      pcBit = 1'b0;

      vecs[0] = '{8'hA5, 1'b1, 1'b1, 1'b1, 1, 0, 1, 1, LAT_PARITY};
      vecs[1] = '{8'h3C, 1'b0, 1'b0, 1'b1, 1, 0, 0, 0, LAT_NOPARITY};
      vecs[2] = '{8'h81, 1'b0, 1'b0, 1'b0, 0, 1, 0, 0, LAT_NOPARITY};
      vecs[3] = '{8'h00, 1'b1, 1'b0, 1'b1, 1, 0, 1, 0, LAT_PARITY};
      vecs[4] = '{8'hFF, 1'b1, 1'b1, 1'b0, 0, 1, 1, 1, LAT_PARITY};

      reset = 1'b0;
      rx_in = 1'b1;
      parity_en = 1'b0;
      repeat (3) @(posedge UCLK);
      #1;
      checkOutput("reset parallel_data", int'(parallel_data), 0);
      checkOutput("reset sampled_bit", int'(sampled_bit), 0);
      checkOutput("reset busy", int'(busy), 0);
      checkOutput("reset strobes", int'({par_chk_en, data_valid, stop_error, start_glitch}), 0);
      reset = 1'b1;
      idleCycles(5);
      checkOutput("idle busy", int'(busy), 0);

      for (int v = 0; v < 5; v++) begin
         dv0 = dvCount;
         se0 = seCount;
         pc0 = pcCount;
         sg0 = sgCount;
         applyStimulus(vecs[v].data, vecs[v].parEn, vecs[v].parBit, vecs[v].stopBit, 1'b0);
         idleCycles(8);
         $display("[TB] frame %0d data 0x%0h", v, vecs[v].data);
         checkOutput("frame data_valid count", dvCount - dv0, vecs[v].expDv);
         checkOutput("frame stop_error count", seCount - se0, vecs[v].expStopErr);
         checkOutput("frame par_chk_en count", pcCount - pc0, vecs[v].expParChk);
         checkOutput("frame start_glitch count", sgCount - sg0, 0);
         checkOutput("frame end latency", endCycle - frameStart, vecs[v].expLatency);
         checkOutput("frame parallel_data", int'(parallel_data), int'(vecs[v].data));
         checkOutput("frame busy after", int'(busy), 0);
         if (vecs[v].expParChk != 0) begin
            checkOutput("parity strobe data", int'(pcData), int'(vecs[v].data));
            checkOutput("parity strobe bit", int'(pcBit), vecs[v].expParBit);
         end
      end

      // Short low pulse: start bit not confirmed at mid-bit.
      dv0 = dvCount;
      pc0 = pcCount;
      sg0 = sgCount;
      frameStart = cycleCount;
      rx_in = 1'b0;
      repeat (4) @(posedge UCLK);
      #1;
      rx_in = 1'b1;
      idleCycles(30);
      checkOutput("glitch start_glitch count", sgCount - sg0, 1);
      checkOutput("glitch latency", glitchCycle - frameStart, LAT_GLITCH);
      checkOutput("glitch data_valid count", dvCount - dv0, 0);
      checkOutput("glitch par_chk_en count", pcCount - pc0, 0);
      checkOutput("glitch busy", int'(busy), 0);

      // Back-to-back noisy frames with no idle gap between them.
      dv0 = dvCount;
      dvLog.delete();
      applyStimulus(8'h55, 1'b0, 1'b0, 1'b1, 1'b1);
      applyStimulus(8'hAA, 1'b0, 1'b0, 1'b1, 1'b1);
      idleCycles(8);
      checkOutput("b2b data_valid count", dvCount - dv0, 2);
      if (dvLog.size() == 2) begin
         checkOutput("b2b first data", int'(dvLog[0]), 8'h55);
         checkOutput("b2b second data", int'(dvLog[1]), 8'hAA);
      end else begin
         checkOutput("b2b log size", dvLog.size(), 2);
      end

      // Reset asserted part way through DATA bit 4.
      dv0 = dvCount;
      se0 = seCount;
      parity_en = 1'b0;
      driveBit(1'b0, 1'b0);
      for (int b = 0; b < 4; b++) begin
         driveBit(1'b1, 1'b0);
      end
      rx_in = 1'b1;
      repeat (8) @(posedge UCLK);
      #1;
      checkOutput("pre-reset busy", int'(busy), 1);
      checkOutput("pre-reset sampled_bit", int'(sampled_bit), 1);
      checkOutput("pre-reset parallel_data", int'(parallel_data), 8'hFA);
      reset = 1'b0;
      #1;
      checkOutput("mid reset parallel_data", int'(parallel_data), 0);
      checkOutput("mid reset sampled_bit", int'(sampled_bit), 0);
      checkOutput("mid reset busy", int'(busy), 0);
      checkOutput("mid reset strobes", int'({par_chk_en, data_valid, stop_error, start_glitch}), 0);
      repeat (3) @(posedge UCLK);
      #1;
      reset = 1'b1;
      idleCycles(40);
      checkOutput("post-reset no strobes", (dvCount - dv0) + (seCount - se0), 0);
      applyStimulus(8'h0F, 1'b0, 1'b0, 1'b1, 1'b0);
      idleCycles(8);
      checkOutput("post-reset data_valid count", dvCount - dv0, 1);
      checkOutput("post-reset parallel_data", int'(parallel_data), 8'h0F);
      checkOutput("post-reset latency", endCycle - frameStart, LAT_NOPARITY);

      checkOutput("strobe exclusivity violations", exclusiveViolations, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

   // Safety net so the run always ends even if the sequences above stall.
   initial begin
      #2000000;
      $display("[TB] FAIL timeout: simulation exceeded time limit");
      failCount++;
      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
